// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame streamer: FSM states, the marker
// bit layout of a buffered pixel word, and small sizing helpers.
package frame_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_HBLANK,
        ST_ACTIVE,
        ST_DRAIN
    } state_t;

    // Buffered word layout is {pixel, sof, eol, eof}; markers sit in the LSBs.
    localparam int MRK_W   = 3;
    localparam int MRK_EOF = 0;
    localparam int MRK_EOL = 1;
    localparam int MRK_SOF = 2;

    // Packed pixel width for a given channel count and channel width.
    function automatic int pix_width(input int ch, input int wi);
        return ch * wi;
    endfunction

    // Number of pixels in one frame.
    function automatic int frame_size(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output buffer between the memory read pipeline and the consumer.
// The caller never pushes when full or pops when empty.
module stream_skid_fifo #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Storage, pointers and occupancy update on push/pop.
    // NOTE: state is assigned with <= so every flop samples pre-edge values,
    // independent of the order of statements within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset because its head drives the pixel
            // output directly, which must read zero after reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/frame_streamer.sv
// Replays a stored frame from a 1-cycle-latency memory as a ready/valid pixel
// stream with vertical and horizontal blanking, frame/line markers and an
// optional free-running mode.
module frame_streamer
    import frame_stream_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 128,
    parameter int CH          = 3,
    parameter int WI          = 8,
    parameter int VSYNC_DELAY = 200,
    parameter int HSYNC_DELAY = 160,
    parameter int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont_mode,
    input  logic              ch_rev,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [CH*WI-1:0]  mem_rdata,
    output logic [CH*WI-1:0]  out_data,
    output logic              out_vld,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int PIX_W      = pix_width(CH, WI);
    localparam int FRAME_SIZE = frame_size(WIDTH, HEIGHT);
    localparam int CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BMAX       = (VSYNC_DELAY > HSYNC_DELAY) ? VSYNC_DELAY : HSYNC_DELAY;
    localparam int BW         = (BMAX > 1) ? $clog2(BMAX) : 1;

    state_t             state_q, state_d;
    logic [BW-1:0]      blank_cnt_q;
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               cont_q, rev_q;
    logic               inflight_q;
    logic [MRK_W-1:0]   mrk_q;

    logic               col_last, row_last, addr_last;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]         fifo_count, level;
    logic               rd_room;
    logic [PIX_W-1:0]   pix_wr;
    logic [PIX_W+MRK_W-1:0] fifo_dout;

    assign col_last  = (col_q == CW'(WIDTH - 1));
    assign row_last  = (row_q == RW'(HEIGHT - 1));
    assign addr_last = (addr_q == ADDR_W'(FRAME_SIZE - 1));

    // Reads in flight plus buffered pixels never exceed the buffer depth.
    assign level     = fifo_count + {1'b0, inflight_q};
    assign fifo_pop  = out_vld & out_ready;
    assign rd_room   = (level < 2'd2) || fifo_pop;
    assign fifo_push = inflight_q & ~fifo_full;

    // Next-state, read strobe and frame_done decode.
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        mem_rd     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_VBLANK;
            ST_VBLANK: if (blank_cnt_q == BW'(VSYNC_DELAY - 1)) state_d = ST_HBLANK;
            ST_HBLANK: if (blank_cnt_q == BW'(HSYNC_DELAY - 1)) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                mem_rd = rd_room;
                if (rd_room && col_last) state_d = row_last ? ST_DRAIN : ST_HBLANK;
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    frame_done = 1'b1;
                    state_d    = cont_q ? ST_VBLANK : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Blanking counter: restarts on every state change, counts in blank states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_cnt_q <= '0;
        end else if (state_d != state_q) begin
            blank_cnt_q <= '0;
        end else if (state_q == ST_VBLANK || state_q == ST_HBLANK) begin
            blank_cnt_q <= blank_cnt_q + BW'(1);
        end
    end

    // Latch the per-frame modes when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q <= 1'b0;
            rev_q  <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            cont_q <= cont_mode;
            rev_q  <= ch_rev;
        end
    end

    // Read position: column, row and linear address advance on each read and
    // wrap to zero at the end of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (mem_rd) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
            addr_q <= addr_last ? '0 : addr_q + ADDR_W'(1);
        end
    end

    // Track the outstanding read and the markers that belong to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            mrk_q      <= '0;
        end else begin
            inflight_q <= mem_rd;
            if (mem_rd) begin
                mrk_q[MRK_SOF] <= (row_q == '0) && (col_q == '0);
                mrk_q[MRK_EOL] <= col_last;
                mrk_q[MRK_EOF] <= col_last && row_last;
            end
        end
    end

    // Optional channel reversal applied to returning memory data.
    always_comb begin
        pix_wr = mem_rdata;
        if (rev_q) begin
            for (int k = 0; k < CH; k++) begin
                pix_wr[(CH-1-k)*WI +: WI] = mem_rdata[k*WI +: WI];
            end
        end
    end

    stream_skid_fifo #(
        .W (PIX_W + MRK_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   ({pix_wr, mrk_q}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_vld  = ~fifo_empty;
    assign out_data = fifo_dout[MRK_W +: PIX_W];
    assign out_sof  = out_vld & fifo_dout[MRK_SOF];
    assign out_eol  = out_vld & fifo_dout[MRK_EOL];
    assign out_eof  = out_vld & fifo_dout[MRK_EOF];
    assign busy     = (state_q != ST_IDLE);
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: a driver issues frames and pushes the
// expected pixels (and, for timed frames, expected event cycles) into queues;
// a monitor pops and compares whenever the DUT presents an event.
module tb_frame_streamer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int VS   = 3;
    localparam int HS   = 2;
    localparam int NPIX = W * H;

    typedef struct {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst, start, cont_mode, ch_rev, out_ready;
    logic        mem_rd, out_vld, out_sof, out_eol, out_eof, busy, frame_done;
    logic [2:0]  mem_addr;
    logic [23:0] mem_rdata, out_data;

    int   cyc = 0;
    int   t0 = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_timeouts = 0;
    bit   cont_flag = 0;
    bit   stim_done = 0;

    pix_t exp_q[$];
    int   rdcyc_q[$];
    int   vldcyc_q[$];
    int   donecyc_q[$];

    frame_streamer #(
        .WIDTH(W), .HEIGHT(H), .CH(3), .WI(8),
        .VSYNC_DELAY(VS), .HSYNC_DELAY(HS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode), .ch_rev(ch_rev),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_vld(out_vld), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] mem_word(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b, b + 8'h40, b + 8'h80};
    endfunction

    // Frame memory with one cycle of read latency.
    always @(posedge clk or posedge rst) begin
        if (rst)         mem_rdata <= '0;
        else if (mem_rd) mem_rdata <= mem_word(int'(mem_addr));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pixel n of the frame is memory word n, channels optionally reversed.
    task automatic push_frame(input bit rev);
        for (int n = 0; n < NPIX; n++) begin
            pix_t        p;
            logic [23:0] w;
            w      = mem_word(n);
            p.data = rev ? {w[7:0], w[15:8], w[23:16]} : w;
            p.sof  = (n == 0);
            p.eol  = ((n % W) == W - 1);
            p.eof  = (n == NPIX - 1);
            exp_q.push_back(p);
        end
    endtask

    // Event cycles of a frame with out_ready held high, relative to the start pulse.
    task automatic push_timing();
        for (int l = 0; l < H; l++) begin
            for (int c = 0; c < W; c++) begin
                rdcyc_q.push_back(1 + VS + HS + l * (HS + W) + c);
                vldcyc_q.push_back(1 + VS + HS + l * (HS + W) + c + 2);
            end
        end
        donecyc_q.push_back(1 + VS + H * (HS + W) + 2);
    endtask

    task automatic start_frame(input bit cont, input bit rev);
        @(posedge clk); #1;
        start     = 1'b1;
        cont_mode = cont;
        ch_rev    = rev;
        cont_flag = cont;
        t0        = cyc;
        push_frame(rev);
    endtask

    // Drive out_ready (and noise on the sampled-at-start inputs) until frame_done.
    task automatic run_frame(input int mode, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = !((cyc - t0) >= 9 && (cyc - t0) <= 12);
                default: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    start     = ($urandom_range(0, 7) == 0);
                    ch_rev    = 1'($urandom_range(0, 1));
                    cont_mode = 1'($urandom_range(0, 1));
                end
            endcase
            @(negedge clk);
            if (frame_done) break;
        end
        if (k == budget) n_timeouts++;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    // Driver.
    initial begin
        rst = 1'b1; start = 1'b0; cont_mode = 1'b0; ch_rev = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Timed single frame with no backpressure.
        push_timing();
        start_frame(0, 0);
        run_frame(0, 200);

        // Channel reversal.
        start_frame(0, 1);
        run_frame(0, 200);

        // Fixed backpressure window.
        start_frame(0, 0);
        run_frame(1, 200);

        // Random backpressure, random modes and stray start pulses.
        for (int i = 0; i < 4; i++) begin
            start_frame(0, 1'($urandom_range(0, 1)));
            run_frame(2, 400);
        end

        // Continuous mode: two back-to-back identical frames, then reset.
        begin
            bit rev;
            rev = 1'($urandom_range(0, 1));
            start_frame(1, rev);
            push_frame(rev);
            run_frame(2, 400);
            run_frame(2, 400);
        end
        @(posedge clk); #1;
        rst = 1'b1; cont_flag = 1'b0; cont_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-frame, then replay from the start.
        start_frame(0, 0);
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        push_timing();
        start_frame(0, 0);
        run_frame(0, 200);

        repeat (3) @(posedge clk);
        #1 stim_done = 1'b1;
    end

    // Monitor and scoreboard.
    initial begin
        pix_t        e;
        int          rel, outst, max_outst, eof_cyc, done_cnt;
        bit          stall_q, done_prev, accept_prev;
        logic [26:0] held;
        logic [2:0]  exp_addr;
        outst = 0; max_outst = 0; eof_cyc = -100; done_cnt = 0;
        stall_q = 0; done_prev = 0; accept_prev = 0; held = '0; exp_addr = '0;
        forever begin
            @(negedge clk);
            if (stim_done) begin
                check("frames_done", done_cnt, 10);
                check("timeouts", n_timeouts, 0);
                check("pixels_left", exp_q.size(), 0);
                check("events_left", rdcyc_q.size() + vldcyc_q.size() + donecyc_q.size(), 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
            if (rst) begin
                check("reset_outputs",
                      {mem_rd, mem_addr, out_data, out_vld, out_sof, out_eol, out_eof, busy, frame_done},
                      '0);
                exp_q.delete(); rdcyc_q.delete(); vldcyc_q.delete(); donecyc_q.delete();
                outst = 0; max_outst = 0; eof_cyc = -100;
                stall_q = 0; done_prev = 0; accept_prev = 0; exp_addr = '0;
            end else begin
                rel = cyc - t0;
                if (accept_prev) check("busy_after_start", busy, 1);
                accept_prev = start && !busy;
                if (done_prev && !cont_flag) check("busy_after_done", busy, 0);
                if (stall_q) begin
                    check("hold_vld", out_vld, 1);
                    check("hold_word", {out_data, out_sof, out_eol, out_eof}, held);
                end
                if (mem_rd) begin
                    check("mem_addr", mem_addr, exp_addr);
                    exp_addr = (exp_addr == 3'(NPIX - 1)) ? 3'd0 : exp_addr + 3'd1;
                    outst++;
                    if (rdcyc_q.size() > 0) check("rd_cycle", rel, rdcyc_q.pop_front());
                end
                if (out_vld && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_data", out_data, e.data);
                        check("pix_markers", {out_sof, out_eol, out_eof}, {e.sof, e.eol, e.eof});
                    end
                    outst--;
                    if (vldcyc_q.size() > 0) check("vld_cycle", rel, vldcyc_q.pop_front());
                    if (out_eof) eof_cyc = cyc;
                end
                if (outst > max_outst) max_outst = outst;
                if (frame_done) begin
                    check("done_after_eof", cyc, eof_cyc + 1);
                    check("max_outstanding_le2", max_outst <= 2, 1);
                    check("outstanding_at_done", outst, 0);
                    if (donecyc_q.size() > 0) check("done_cycle", rel, donecyc_q.pop_front());
                    done_cnt++;
                    max_outst = 0;
                end
                done_prev = frame_done;
                stall_q   = out_vld && !out_ready;
                held      = {out_data, out_sof, out_eol, out_eof};
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

endmodule
